// File: rtl/dot_matrix_scan_capture_if.sv
// Scan bus and rebuilt-frame outputs between the dot-matrix scanner side and the capture monitor.
// The master drives the row/column bus; the slave publishes frames and status.
interface dot_matrix_scan_capture_if;
    logic [7:0]  ROW_in;
    logic [7:0]  R_COL_in;
    logic [7:0]  G_COL_in;
    logic [63:0] frame_R;
    logic [63:0] frame_G;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
    logic        row_err;
    logic        scan_stall;

    modport master (
        output ROW_in, R_COL_in, G_COL_in,
        input  frame_R, frame_G, frame_valid, frame_cnt, row_err, scan_stall
    );

    modport slave (
        input  ROW_in, R_COL_in, G_COL_in,
        output frame_R, frame_G, frame_valid, frame_cnt, row_err, scan_stall
    );
endinterface

// File: rtl/dot_matrix_scan_capture.sv
// Rebuilds 8x8 red/green frames from the multiplexed ROW/R_COL/G_COL scan bus and publishes
// each complete in-order frame with a one-cycle strobe.
//  state   | meaning
//  IDLE    | waiting for a row-0 capture to start a frame
//  COLLECT | rows 0..exp_row-1 captured in order, waiting for exp_row
//  PUBLISH | all eight rows present, copy shadow to frame outputs
module dot_matrix_scan_capture #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 1024
) (
    input logic                     clk_in,
    input logic                     rst,
    dot_matrix_scan_capture_if.slave bus
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_V  = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

    state_t      state;
    logic [7:0]  row_m, row_s, row_q;
    logic [7:0]  r_m, r_s, g_m, g_s;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] idle_cnt;
    logic [63:0] shadow_r, shadow_g;
    logic [63:0] frame_r, frame_g;
    logic [7:0]  seen;
    logic [3:0]  exp_row;
    logic [7:0]  frame_cnt;
    logic        frame_valid, row_err;

    logic        row_diff, cap_fire, row_blank, row_legal;
    logic [2:0]  row_idx;
    logic [7:0]  row_bit;

    assign row_diff  = (row_s != row_q);
    // A one-cycle settle window captures on the very cycle the new row appears.
    assign cap_fire  = row_diff ? (SETTLE_CYCLES == 1) : (stable_cnt == SETTLE_M1);
    assign row_blank = (row_s == 8'hFF);
    assign row_legal = $onehot(~row_s);
    assign row_bit   = 8'h01 << row_idx;

    always_comb begin
        row_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (!row_s[i]) row_idx = 3'(i);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            row_m <= 8'hFF; row_s <= 8'hFF; row_q <= 8'hFF;
            r_m <= '0; r_s <= '0; g_m <= '0; g_s <= '0;
        end else begin
            row_m <= bus.ROW_in;   row_s <= row_m; row_q <= row_s;
            r_m   <= bus.R_COL_in; r_s   <= r_m;
            g_m   <= bus.G_COL_in; g_s   <= g_m;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stable_cnt  <= '0;
            idle_cnt    <= '0;
            shadow_r    <= '0;
            shadow_g    <= '0;
            frame_r     <= '0;
            frame_g     <= '0;
            seen        <= '0;
            exp_row     <= '0;
            frame_cnt   <= '0;
            frame_valid <= 1'b0;
            row_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            row_err     <= 1'b0;

            if (row_diff)                   stable_cnt <= SW'(1);
            else if (stable_cnt != SETTLE_V) stable_cnt <= stable_cnt + SW'(1);

            if (cap_fire)                   idle_cnt <= '0;
            else if (idle_cnt != TIMEOUT_V) idle_cnt <= idle_cnt + TW'(1);

            if (state == PUBLISH) begin
                // An illegal code landing on the publish cycle suppresses the frame.
                if (cap_fire && !row_blank && !row_legal) begin
                    row_err <= 1'b1;
                end else begin
                    frame_r     <= shadow_r;
                    frame_g     <= shadow_g;
                    frame_valid <= 1'b1;
                    frame_cnt   <= frame_cnt + 8'd1;
                end
                seen  <= '0;
                state <= IDLE;
            end else if (cap_fire) begin
                if (!row_blank) begin
                    if (!row_legal) begin
                        row_err <= 1'b1;
                        seen    <= '0;
                        state   <= IDLE;
                    end else if (state == IDLE) begin
                        if (row_idx == 3'd0) begin
                            shadow_r[7:0] <= r_s;
                            shadow_g[7:0] <= g_s;
                            seen          <= 8'h01;
                            exp_row       <= 4'd1;
                            state         <= COLLECT;
                        end
                    end else if ({1'b0, row_idx} == exp_row) begin
                        shadow_r[{row_idx, 3'b000} +: 8] <= r_s;
                        shadow_g[{row_idx, 3'b000} +: 8] <= g_s;
                        seen    <= seen | row_bit;
                        exp_row <= exp_row + 4'd1;
                        if (row_idx == 3'd7 && (seen | row_bit) == 8'hFF) state <= PUBLISH;
                    end else if ({1'b0, row_idx} + 4'd1 == exp_row) begin
                        shadow_r[{row_idx, 3'b000} +: 8] <= r_s;
                        shadow_g[{row_idx, 3'b000} +: 8] <= g_s;
                    end else begin
                        row_err <= 1'b1;
                        seen    <= '0;
                        state   <= IDLE;
                    end
                end
            end else if (idle_cnt == TIMEOUT_M1) begin
                seen  <= '0;
                state <= IDLE;
            end
        end
    end

    assign bus.frame_R     = frame_r;
    assign bus.frame_G     = frame_g;
    assign bus.frame_valid = frame_valid;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.row_err     = row_err;
    assign bus.scan_stall  = (idle_cnt == TIMEOUT_V);
endmodule
